// File: rtl/pipe_regchain.sv
// Multi-stage register chain with per-stage stall/flush, holding the youngest payload in stage 0.
// Latency is STAGES edges from presentation to out_data, and a held stage back-propagates hold toward stage 0.
module pipe_regchain #(
   parameter int STAGES = 4,
   parameter int WIDTH  = 64,
   parameter int CNTW   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   input  logic [STAGES-1:0]           stall,
   input  logic [STAGES-1:0]           flush,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready,
   output logic [$clog2(STAGES+1)-1:0] occupancy,
   output logic [CNTW-1:0]             stall_cnt,
   output logic [CNTW-1:0]             flush_cnt
);

   localparam int OCCW = $clog2(STAGES+1);

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
   logic [CNTW-1:0]              stall_cnt_q, stall_cnt_d;
   logic [CNTW-1:0]              flush_cnt_q, flush_cnt_d;
   logic [STAGES-1:0]            hold;
   logic [STAGES-1:0]            kill;
   logic                         any_flush;

   assign out_valid = valid_q[STAGES-1] & ~rst;
   assign out_data  = data_q[STAGES-1];
   assign any_flush = |flush;
   assign in_ready  = ~hold[0] & ~any_flush & ~rst;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // hold ripples down from the output stage; kill covers every stage at or below the highest flush bit
   always_comb begin : hold_kill
      logic h;
      logic f;
      h    = out_valid & ~out_ready;
      f    = 1'b0;
      hold = '0;
      kill = '0;
      for (int k = STAGES-1; k >= 0; k--) begin
         h       = h | stall[k];
         f       = f | flush[k];
         hold[k] = h;
         kill[k] = f;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (kill[0]) begin
         valid_d[0] = 1'b0;
      end else if (!hold[0]) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (kill[k]) begin
            valid_d[k] = 1'b0;
         end else if (!hold[k]) begin
            // a held or killed source cannot advance, so its successor takes a bubble
            if (hold[k-1] || kill[k-1]) begin
               valid_d[k] = 1'b0;
            end else begin
               valid_d[k] = valid_q[k-1];
               data_d[k]  = data_q[k-1];
            end
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (in_valid && !in_ready && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
      if (any_flush && flush_cnt_q != '1) begin
         flush_cnt_d = flush_cnt_q + CNTW'(1);
      end
   end

   always_comb begin
      occupancy = '0;
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCCW'(valid_q[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         data_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         data_q      <= data_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_regchain.sv
// Directed bench for pipe_regchain (4 stages, 8-bit payload, 8-bit counters) with a per-cycle
// stage-rule model and hand-computed literal expectations.
module tb_pipe_regchain;

   localparam int S    = 4;
   localparam int W    = 8;
   localparam int CW   = 8;
   localparam int CMAX = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic [S-1:0]  stall;
   logic [S-1:0]  flush;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [2:0]    occupancy;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;
   bit chk_en    = 1'b0;

   // model state: per-stage valid/data plus the two counters
   bit         mv [S];
   logic [W-1:0] md [S];
   int         m_stall;
   int         m_flush;

   pipe_regchain #(.STAGES(S), .WIDTH(W), .CNTW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      else pass_cnt++;
   endtask

   // stage k is held if any stall at or above it is set, or the output is blocked
   function automatic bit m_hold(input int k);
      bit h;
      h = mv[S-1] && !out_ready;
      for (int j = S-1; j >= k; j--) h = h | stall[j];
      return h;
   endfunction

   function automatic bit m_in_ready();
      return !rst && !m_hold(0) && (flush == '0);
   endfunction

   function automatic int m_occ();
      int n;
      n = 0;
      if (!rst) for (int k = 0; k < S; k++) n += int'(mv[k]);
      return n;
   endfunction

   always @(posedge clk) begin : model_step
      bit           nv [S];
      logic [W-1:0] nd [S];
      bit           hk [S];
      bit           ir;
      int           m;
      if (rst) begin
         for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
         end
         m_stall = 0;
         m_flush = 0;
      end else begin
         ir = m_in_ready();
         for (int k = 0; k < S; k++) hk[k] = m_hold(k);
         m = -1;
         for (int j = 0; j < S; j++) if (flush[j]) m = j;
         if (in_valid && !ir && m_stall < CMAX) m_stall++;
         if (flush != '0 && m_flush < CMAX) m_flush++;
         for (int k = 0; k < S; k++) begin
            nv[k] = mv[k];
            nd[k] = md[k];
            if (k <= m) nv[k] = 1'b0;
            else if (hk[k]) nv[k] = mv[k];
            else if (k == 0) begin
               nv[k] = in_valid;
               nd[k] = in_data;
            end else if (k - 1 <= m || hk[k-1]) nv[k] = 1'b0;
            else begin
               nv[k] = mv[k-1];
               nd[k] = md[k-1];
            end
         end
         for (int k = 0; k < S; k++) begin
            mv[k] = nv[k];
            md[k] = nd[k];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_in_ready", 32'(in_ready), 32'(m_in_ready()));
         check("m_out_valid", 32'(out_valid), 32'(!rst && mv[S-1]));
         if (!rst && mv[S-1]) check("m_out_data", 32'(out_data), 32'(md[S-1]));
         check("m_occupancy", 32'(occupancy), 32'(m_occ()));
         check("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
         check("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // leaves s0..s3 = 0D,0C,0B,0A with in_valid low; assumes an empty pipe and out_ready=1
   task automatic fill();
      logic [W-1:0] vals [4];
      vals = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         cyc();
      end
      in_valid = 1'b0;
      #1;
      check("fill_occ", 32'(occupancy), 32'd4);
      check("fill_out", 32'(out_data), 32'h0A);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      stall = '0; flush = '0; out_ready = 1'b1;

      // reset state
      cyc();
      chk_en = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // back-to-back stream, 4-edge latency
      in_valid = 1'b1; in_data = 8'h11; cyc();
      in_data = 8'h22; cyc();
      in_data = 8'h33; cyc();
      check("stream_occ_peak", 32'(occupancy), 32'd3);
      in_valid = 1'b0; cyc();
      check("stream_v0", 32'(out_valid), 32'd1);
      check("stream_d0", 32'(out_data), 32'h11);
      cyc(); check("stream_d1", 32'(out_data), 32'h22);
      cyc(); check("stream_d2", 32'(out_data), 32'h33);
      cyc(); check("stream_end", 32'(out_valid), 32'd0);

      // stall on stage 1 splits the chain and inserts a bubble into stage 2
      fill();
      stall = 4'b0010; in_valid = 1'b1; in_data = 8'h0E;
      #1; check("stall_in_ready", 32'(in_ready), 32'd0);
      cyc();
      stall = '0; in_valid = 1'b0;
      check("stall_out_b", 32'(out_data), 32'h0B);
      check("stall_occ", 32'(occupancy), 32'd3);
      check("stall_cnt1", 32'(stall_cnt), 32'd1);
      cyc(); check("stall_bubble", 32'(out_valid), 32'd0);
      cyc(); check("stall_out_c", 32'(out_data), 32'h0C);
      cyc(); check("stall_out_d", 32'(out_data), 32'h0D);
      cyc(); check("stall_empty", 32'(occupancy), 32'd0);

      // flush[2] with a full pipe: A leaves, everything else is killed
      fill();
      flush = 4'b0100; cyc(); flush = '0;
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_ov", 32'(out_valid), 32'd0);
      check("flush_cnt1", 32'(flush_cnt), 32'd1);

      // flush of the output stage while blocked
      fill();
      out_ready = 1'b0; flush = 4'b1000; cyc();
      flush = '0; out_ready = 1'b1;
      check("flush3_occ", 32'(occupancy), 32'd0);
      check("flush_cnt2", 32'(flush_cnt), 32'd2);

      // downstream blocked 5 cycles, then drains in order
      rst = 1'b1; cyc(); rst = 1'b0;
      fill();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0E;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("freeze_out", 32'(out_data), 32'h0A);
         check("freeze_occ", 32'(occupancy), 32'd4);
      end
      check("freeze_stall_cnt", 32'(stall_cnt), 32'd5);
      out_ready = 1'b1; in_valid = 1'b0;
      cyc(); check("drain_b", 32'(out_data), 32'h0B);
      cyc(); check("drain_c", 32'(out_data), 32'h0C);
      cyc(); check("drain_d", 32'(out_data), 32'h0D);
      cyc(); check("drain_end", 32'(out_valid), 32'd0);

      // stall and flush together: flush wins
      fill();
      stall = 4'b0010; flush = 4'b0100; cyc();
      stall = '0; flush = '0;
      check("sf_occ", 32'(occupancy), 32'd0);
      check("sf_flush_cnt", 32'(flush_cnt), 32'd1);

      // reset mid-stream
      fill();
      in_valid = 1'b1; in_data = 8'h0E; rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_ov_comb", 32'(out_valid), 32'd0);
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      check("midrst_occ", 32'(occupancy), 32'd0);
      check("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
      cyc(); check("midrst_no_leak", 32'(out_valid), 32'd0);

      // counter saturation
      fill();
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (260) cyc();
      check("stall_sat", 32'(stall_cnt), 32'hFF);
      flush = 4'b0001;
      repeat (260) cyc();
      check("flush_sat", 32'(flush_cnt), 32'hFF);
      check("stall_still_sat", 32'(stall_cnt), 32'hFF);
      flush = '0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) cyc();

      // mixed directed pattern checked by the model each cycle
      for (int i = 0; i < 48; i++) begin
         in_valid  = (i % 7) != 3;
         in_data   = 8'(8'h40 + i);
         out_ready = (i % 3) != 0;
         stall     = (i % 5 == 0) ? 4'b0100 : ((i % 11 == 4) ? 4'b0001 : 4'b0000);
         flush     = (i == 20) ? 4'b0010 : ((i == 37) ? 4'b1000 : 4'b0000);
         cyc();
      end
      stall = '0; flush = '0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) cyc();
      check("final_empty", 32'(occupancy), 32'd0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
